// File: rtl/cmos_frame_mux.sv
// N-channel camera stream selector: forwards one vsync/href/data stream and switches
// channels only on frame boundaries, driven by a debounced key or auto-rotation.
module cmos_frame_mux #(
    parameter int NUM_CH          = 4,
    parameter int DATA_W          = 8,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int AUTO_FRAMES     = 60,
    parameter int SWITCH_TIMEOUT  = 2400000,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_n,
    input  logic                     mode_auto,
    input  logic [NUM_CH-1:0]        cam_vsync,
    input  logic [NUM_CH-1:0]        cam_href,
    input  logic [NUM_CH*DATA_W-1:0] cam_d,
    output logic                     out_vsync,
    output logic                     out_href,
    output logic [DATA_W-1:0]        out_d,
    output logic [CH_W-1:0]          active_ch,
    output logic                     switching,
    output logic [15:0]              frame_cnt,
    output logic                     switch_err
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(SWITCH_TIMEOUT + 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(SWITCH_TIMEOUT - 1);
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [15:0]     AUTO_LAST = 16'(AUTO_FRAMES);
    localparam bit              MULTI_CH  = (NUM_CH > 1);

    typedef enum logic [1:0] {
        PASS     = 2'd0,
        WAIT_END = 2'd1,
        WAIT_NEW = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CH_W-1:0]    active_ch_reg;
    logic [CH_W-1:0]    pending_reg;
    logic [15:0]        frame_cnt_reg;
    logic [TO_W-1:0]    timer_reg;
    logic               boot_reg;
    logic               mode_prev_reg;
    logic               switching_reg;
    logic               switch_err_reg;
    logic [NUM_CH-1:0]  vs_prev_reg;

    logic               key_meta_reg;
    logic               key_sync_reg;
    logic               key_db_reg;
    logic [DB_W-1:0]    db_cnt_reg;

    logic               out_vsync_reg;
    logic               out_href_reg;
    logic [DATA_W-1:0]  out_d_reg;

    logic [DATA_W-1:0]  cam_d_arr [NUM_CH];
    logic [NUM_CH-1:0]  vs_rise;
    logic               act_rise;
    logic               pend_rise;
    logic               press_evt;
    logic               auto_req;
    logic               request;
    logic [CH_W-1:0]    next_ch;
    logic [CH_W-1:0]    fwd_sel;
    logic               fwd_en;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign cam_d_arr[gi] = cam_d[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Key: two-flop synchroniser, then the debounced level only follows a level
    // that has held for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_reg <= 1'b1;
            key_sync_reg <= 1'b1;
            key_db_reg   <= 1'b1;
            db_cnt_reg   <= '0;
        end else begin
            key_meta_reg <= key_n;
            key_sync_reg <= key_meta_reg;
            if (key_sync_reg != key_db_reg) begin
                if (db_cnt_reg == DB_LAST) begin
                    key_db_reg <= key_sync_reg;
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end else begin
                db_cnt_reg <= '0;
            end
        end
    end

    assign press_evt = key_db_reg && !key_sync_reg && (db_cnt_reg == DB_LAST);

    assign vs_rise   = cam_vsync & ~vs_prev_reg;
    assign act_rise  = vs_rise[active_ch_reg];
    assign pend_rise = vs_rise[pending_reg];
    assign auto_req  = mode_auto && (state_reg == PASS) && act_rise && (frame_cnt_reg == AUTO_LAST);
    assign request   = MULTI_CH && (state_reg == PASS) && (press_evt || auto_req);
    assign next_ch   = (active_ch_reg == CH_LAST) ? '0 : active_ch_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= WAIT_NEW;
            active_ch_reg  <= '0;
            pending_reg    <= '0;
            frame_cnt_reg  <= '0;
            timer_reg      <= '0;
            boot_reg       <= 1'b1;
            mode_prev_reg  <= 1'b0;
            switching_reg  <= 1'b0;
            switch_err_reg <= 1'b0;
            vs_prev_reg    <= '0;
        end else begin
            vs_prev_reg    <= cam_vsync;
            mode_prev_reg  <= mode_auto;
            switch_err_reg <= 1'b0;
            case (state_reg)
                PASS: begin
                    switching_reg <= request;
                    if (request) begin
                        pending_reg <= next_ch;
                        state_reg   <= WAIT_END;
                    end else if (act_rise) begin
                        frame_cnt_reg <= frame_cnt_reg + 16'd1;
                    end
                end
                WAIT_END: begin
                    switching_reg <= 1'b1;
                    if (act_rise) begin
                        state_reg <= WAIT_NEW;
                        timer_reg <= '0;
                    end
                end
                WAIT_NEW: begin
                    if (pend_rise) begin
                        active_ch_reg <= pending_reg;
                        frame_cnt_reg <= '0;
                        boot_reg      <= 1'b0;
                        state_reg     <= PASS;
                        switching_reg <= 1'b0;
                    end else if (timer_reg == TO_LAST) begin
                        // Give up on the new channel and resync to the old one.
                        timer_reg     <= '0;
                        pending_reg   <= active_ch_reg;
                        frame_cnt_reg <= '0;
                        switch_err_reg <= !boot_reg;
                        switching_reg <= MULTI_CH;
                    end else begin
                        timer_reg     <= timer_reg + 1'b1;
                        switching_reg <= MULTI_CH;
                    end
                end
                default: begin
                    state_reg     <= WAIT_NEW;
                    switching_reg <= MULTI_CH;
                end
            endcase
            if (mode_auto != mode_prev_reg) begin
                frame_cnt_reg <= '0;
            end
        end
    end

    // The vsync that ends the old frame is swallowed; the one starting the new frame passes.
    assign fwd_sel = (state_reg == WAIT_NEW) ? pending_reg : active_ch_reg;
    assign fwd_en  = (state_reg == PASS) ||
                     ((state_reg == WAIT_END) && !act_rise) ||
                     ((state_reg == WAIT_NEW) && pend_rise);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vsync_reg <= 1'b0;
            out_href_reg  <= 1'b0;
            out_d_reg     <= '0;
        end else begin
            out_vsync_reg <= fwd_en && cam_vsync[fwd_sel];
            out_href_reg  <= fwd_en && cam_href[fwd_sel];
            if (fwd_en && cam_href[fwd_sel]) begin
                out_d_reg <= cam_d_arr[fwd_sel];
            end
        end
    end

    assign out_vsync  = out_vsync_reg;
    assign out_href   = out_href_reg;
    assign out_d      = out_d_reg;
    assign active_ch  = active_ch_reg;
    assign switching  = switching_reg;
    assign frame_cnt  = frame_cnt_reg;
    assign switch_err = switch_err_reg;

endmodule

// File: tb/tb_cmos_frame_mux.sv
// Directed bench for cmos_frame_mux: three synthetic cameras with 400-cycle frames,
// offset in phase, exercising key switching, auto-rotate and the switch timeout.
module tb_cmos_frame_mux;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int P      = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_n = 1'b1;
    logic mode_auto = 1'b0;
    logic [NUM_CH-1:0]        cam_vsync;
    logic [NUM_CH-1:0]        cam_href;
    logic [NUM_CH*DATA_W-1:0] cam_d;
    logic                     out_vsync;
    logic                     out_href;
    logic [DATA_W-1:0]        out_d;
    logic [1:0]               active_ch;
    logic                     switching;
    logic [15:0]              frame_cnt;
    logic                     switch_err;

    int tests = 0;
    int fails = 0;
    int gcyc  = 0;
    logic [NUM_CH-1:0] vs_en = '1;
    int off [NUM_CH] = '{0, 133, 266};

    cmos_frame_mux #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEBOUNCE_CYCLES(16),
        .AUTO_FRAMES(2), .SWITCH_TIMEOUT(1000)
    ) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .mode_auto(mode_auto),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
        .out_vsync(out_vsync), .out_href(out_href), .out_d(out_d),
        .active_ch(active_ch), .switching(switching), .frame_cnt(frame_cnt),
        .switch_err(switch_err)
    );

    always #5 clk = ~clk;

    // Camera i: vsync at phase 0..1, lines of 16 active pixels every 20 cycles.
    task automatic drive_cams();
        for (int i = 0; i < NUM_CH; i++) begin
            int p;
            p = (gcyc + off[i]) % P;
            cam_vsync[i] = vs_en[i] && (p < 2);
            cam_href[i]  = (p >= 10) && (p < 300) && (((p - 10) % 20) < 16);
            cam_d[i*DATA_W +: DATA_W] = cam_href[i] ? 8'(p * 3 + i * 85) : 8'h00;
        end
    endtask

    initial begin
        drive_cams();
        forever begin
            @(negedge clk);
            gcyc++;
            drive_cams();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        while ((gcyc % P) != ph && n <= P) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_switching(input logic level, input int limit, output bit ok);
        int n;
        n = 0;
        while (switching !== level && n < limit) begin
            tick();
            n++;
        end
        ok = (switching === level);
    endtask

    task automatic press_key();
        key_n = 1'b0;
        repeat (24) tick();
        key_n = 1'b1;
        repeat (24) tick();
    endtask

    task automatic test_reset();
        int n;
        int leak;
        bit seen;
        rst = 1'b1;
        repeat (3) tick();
        tests++;
        if ({out_vsync, out_href, out_d, active_ch, switching, frame_cnt, switch_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got vs=%b hr=%b d=%h ch=%0d sw=%b fc=%0d err=%b, required all 0",
                     out_vsync, out_href, out_d, active_ch, switching, frame_cnt, switch_err);
        end
        rst = 1'b0;
        repeat (2) tick();
        tests++;
        if (switching !== 1'b1) begin
            fails++;
            $display("FAIL boot_switching: got %b required 1", switching);
        end
        n = 0; leak = 0; seen = 0;
        while (!seen && n < 1000) begin
            if (out_vsync === 1'b1) seen = 1;
            else begin
                if (out_href !== 1'b0) leak++;
                tick();
                n++;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL first_vsync_timeout: no out_vsync within 1000 cycles");
        end
        tests++;
        if ((gcyc % P) != 0) begin
            fails++;
            $display("FAIL first_vsync_phase: got ch0 phase %0d required 0", gcyc % P);
        end
        tests++;
        if (leak != 0) begin
            fails++;
            $display("FAIL boot_href_leak: got %0d href cycles required 0", leak);
        end
        tests++;
        if (active_ch !== 2'd0 || switching !== 1'b0 || frame_cnt !== 16'd0) begin
            fails++;
            $display("FAIL boot_pass_state: got ch=%0d sw=%b fc=%0d required ch=0 sw=0 fc=0",
                     active_ch, switching, frame_cnt);
        end
    endtask

    task automatic test_datapath();
        int errs;
        logic [7:0] last_d;
        errs = 0;
        last_d = 8'h00;
        repeat (P) begin
            tick();
            if (cam_href[0]) last_d = cam_d[7:0];
            if (out_vsync !== cam_vsync[0] || out_href !== cam_href[0] || out_d !== last_d) errs++;
        end
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL datapath_ch0: got %0d mismatching cycles required 0", errs);
        end
        tests++;
        if (frame_cnt !== 16'd1) begin
            fails++;
            $display("FAIL frame_cnt_one: got %0d required 1", frame_cnt);
        end
    endtask

    task automatic test_debounce();
        key_n = 1'b0;
        repeat (10) tick();
        key_n = 1'b1;
        repeat (40) tick();
        tests++;
        if (switching !== 1'b0 || active_ch !== 2'd0) begin
            fails++;
            $display("FAIL bounce_ignored: got sw=%b ch=%0d required sw=0 ch=0", switching, active_ch);
        end
    endtask

    task automatic test_key_switch();
        int errs;
        int n;
        wait_phase(50);
        key_n = 1'b0;
        repeat (20) tick();
        key_n = 1'b1;
        repeat (5) tick();
        tests++;
        if (switching !== 1'b1 || active_ch !== 2'd0) begin
            fails++;
            $display("FAIL press_request: got sw=%b ch=%0d required sw=1 ch=0", switching, active_ch);
        end
        errs = 0; n = 0;
        while ((gcyc % P) != 0 && n < P) begin
            if (out_href !== cam_href[0] || out_vsync !== cam_vsync[0]) errs++;
            tick();
            n++;
        end
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL wait_end_forward: got %0d mismatching cycles required 0", errs);
        end
        tests++;
        if (out_vsync !== 1'b0 || out_href !== 1'b0) begin
            fails++;
            $display("FAIL end_vsync_dropped: got vs=%b hr=%b required 0 0", out_vsync, out_href);
        end
        errs = 0; n = 0;
        do begin
            tick();
            n++;
            if ((gcyc % P) != 267 && (out_vsync !== 1'b0 || out_href !== 1'b0 || switching !== 1'b1)) errs++;
        end while ((gcyc % P) != 267 && n < P);
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL wait_new_quiet: got %0d bad cycles required 0", errs);
        end
        tests++;
        if (out_vsync !== 1'b1 || active_ch !== 2'd1 || frame_cnt !== 16'd0 || switching !== 1'b0) begin
            fails++;
            $display("FAIL switched_to_ch1: got vs=%b ch=%0d fc=%0d sw=%b required vs=1 ch=1 fc=0 sw=0",
                     out_vsync, active_ch, frame_cnt, switching);
        end
    endtask

    task automatic test_wrap_and_drop();
        bit ok;
        press_key();
        tests++;
        if (switching !== 1'b1) begin
            fails++;
            $display("FAIL press_to_ch2: got sw=%b required 1", switching);
        end
        press_key();
        wait_switching(1'b0, 2000, ok);
        tests++;
        if (!ok || active_ch !== 2'd2) begin
            fails++;
            $display("FAIL active_ch2: got sw=%b ch=%0d required sw=0 ch=2", switching, active_ch);
        end
        repeat (100) tick();
        tests++;
        if (switching !== 1'b0 || active_ch !== 2'd2) begin
            fails++;
            $display("FAIL dropped_press: got sw=%b ch=%0d required sw=0 ch=2", switching, active_ch);
        end
        press_key();
        wait_switching(1'b0, 2000, ok);
        tests++;
        if (!ok || active_ch !== 2'd0) begin
            fails++;
            $display("FAIL wrap_to_ch0: got sw=%b ch=%0d required sw=0 ch=0", switching, active_ch);
        end
    endtask

    task automatic test_auto();
        bit ok;
        logic [1:0] exp_ch;
        mode_auto = 1'b1;
        exp_ch = 2'd0;
        for (int r = 0; r < 3; r++) begin
            wait_switching(1'b1, 3000, ok);
            tests++;
            if (!ok || frame_cnt !== 16'd2 || active_ch !== exp_ch) begin
                fails++;
                $display("FAIL auto_request_%0d: got sw=%b fc=%0d ch=%0d required sw=1 fc=2 ch=%0d",
                         r, switching, frame_cnt, active_ch, exp_ch);
            end
            exp_ch = (exp_ch == 2'd2) ? 2'd0 : exp_ch + 2'd1;
            wait_switching(1'b0, 2000, ok);
            tests++;
            if (!ok || active_ch !== exp_ch || frame_cnt !== 16'd0) begin
                fails++;
                $display("FAIL auto_switch_%0d: got sw=%b ch=%0d fc=%0d required sw=0 ch=%0d fc=0",
                         r, switching, active_ch, frame_cnt, exp_ch);
            end
        end
        mode_auto = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int g0;
        int n;
        bit ok;
        vs_en[1] = 1'b0;
        wait_phase(50);
        press_key();
        wait_phase(0);
        g0 = gcyc;
        tests++;
        if (switching !== 1'b1) begin
            fails++;
            $display("FAIL timeout_switching: got %b required 1", switching);
        end
        n = 0;
        while (switch_err !== 1'b1 && n < 1200) begin
            tick();
            n++;
        end
        tests++;
        if (gcyc - g0 != 1000) begin
            fails++;
            $display("FAIL switch_err_delay: got %0d cycles required 1000", gcyc - g0);
        end
        tests++;
        if (active_ch !== 2'd0 || frame_cnt !== 16'd0) begin
            fails++;
            $display("FAIL timeout_state: got ch=%0d fc=%0d required ch=0 fc=0", active_ch, frame_cnt);
        end
        tick();
        tests++;
        if (switch_err !== 1'b0) begin
            fails++;
            $display("FAIL switch_err_pulse: got %b required 0 one cycle later", switch_err);
        end
        wait_switching(1'b0, 600, ok);
        tests++;
        if (!ok || active_ch !== 2'd0) begin
            fails++;
            $display("FAIL timeout_resync: got sw=%b ch=%0d required sw=0 ch=0", switching, active_ch);
        end
        vs_en[1] = 1'b1;
    endtask

    task automatic test_reset_mid();
        key_n = 1'b0;
        repeat (24) tick();
        key_n = 1'b1;
        tick();
        rst = 1'b1;
        #2;
        tests++;
        if ({out_vsync, out_href, out_d, active_ch, switching, frame_cnt, switch_err} !== '0) begin
            fails++;
            $display("FAIL reset_mid: got vs=%b hr=%b d=%h ch=%0d sw=%b fc=%0d err=%b, required all 0",
                     out_vsync, out_href, out_d, active_ch, switching, frame_cnt, switch_err);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_datapath();
        test_debounce();
        test_key_switch();
        test_wrap_and_drop();
        test_auto();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
